hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 96 +++++++++
 tb/tb_hazard_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall and operand forwarding select for a 5-stage pipeline
// Optional stall_cnt output is built when HAZARD_STALL_CNT_EN is defined.
module hazard_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs1,
  output logic [1:0] fwd_rs2,
  output logic [4:0] ex_rd,
  output logic [4:0] mem_rd,
  output logic [4:0] wb_rd,
  output logic       wb_reg_write
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, ex_d;

  // x0 and non-writing slots never produce a hazard.
  function automatic logic hit(input slot_t s, input logic [4:0] rs);
    return s.rw && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

  function automatic logic [1:0] sel(input slot_t e, input slot_t m, input slot_t w,
                                     input logic [4:0] rs);
    if (hit(e, rs))      return 2'b01;
    else if (hit(m, rs)) return 2'b10;
    else if (hit(w, rs)) return 2'b11;
    else                 return 2'b00;
  endfunction

  always_comb begin
    stall   = id_valid && !flush && ex_q.mr && (hit(ex_q, id_rs1) || hit(ex_q, id_rs2));
    fwd_rs1 = 2'b00;
    fwd_rs2 = 2'b00;
    if (id_valid) begin
      fwd_rs1 = sel(ex_q, mem_q, wb_q, id_rs1);
      fwd_rs2 = sel(ex_q, mem_q, wb_q, id_rs2);
    end
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.rd = id_rd;
      ex_d.rw = id_reg_write;
      ex_d.mr = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_rd        = ex_q.rd;
  assign mem_rd       = mem_q.rd;
  assign wb_rd        = wb_q.rd;
  assign wb_reg_write = wb_q.rw;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - vector table, corner sequences and random model check for hazard_unit
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic       stall;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       wb_reg_write;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: history of instructions that entered EX, newest first; index = distance - 1.
  typedef struct {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;
  ins_t hist[$];
  logic [31:0] cnt_m;

  function automatic ins_t bubble();
    ins_t b;
    b.rd = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  function automatic logic [1:0] model_fwd(input logic v, input logic [4:0] rs);
    if (!v) return 2'd0;
    for (int d = 0; d < 3; d++)
      if (hist[d].rw && hist[d].rd != 0 && hist[d].rd == rs) return 2'(d + 1);
    return 2'd0;
  endfunction

  task automatic model_reset();
    hist = {bubble(), bubble(), bubble()};
    cnt_m = 0;
  endtask

  task automatic apply(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    logic exp_stall;
    ins_t nw;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
    exp_stall = v && !fl && hist[0].mr && hist[0].rw && hist[0].rd != 0 &&
                (hist[0].rd == rs1 || hist[0].rd == rs2);
    chk("m_stall", 32'(stall), 32'(exp_stall));
    chk("m_fwd1", 32'(fwd_rs1), 32'(model_fwd(v, rs1)));
    chk("m_fwd2", 32'(fwd_rs2), 32'(model_fwd(v, rs2)));
    chk("m_ex_rd", 32'(ex_rd), 32'(hist[0].rd));
    chk("m_mem_rd", 32'(mem_rd), 32'(hist[1].rd));
    chk("m_wb_rd", 32'(wb_rd), 32'(hist[2].rd));
    chk("m_wb_rw", 32'(wb_reg_write), 32'(hist[2].rw));
`ifdef HAZARD_STALL_CNT_EN
    chk("m_stall_cnt", stall_cnt, cnt_m);
`endif
    @(posedge clk);
    nw = bubble();
    if (v && !exp_stall && !fl) begin nw.rd = rd; nw.rw = rw; nw.mr = mr; end
    hist.push_front(nw);
    void'(hist.pop_back());
    if (exp_stall && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    id_valid = 0; flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic load_use(input logic [4:0] r);
    apply(1, 0, 0, r, 1, 1, 0);
    apply(1, r, 0, 0, 0, 0, 0);
    apply(1, r, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, fl;
    logic       e_stall;
    logic [1:0] e_f1, e_f2;
    logic [4:0] e_ex, e_mem, e_wb;
    logic       e_wbw;
  } vec_t;
  vec_t vecs[19];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic fl, input logic s, input logic [1:0] f1,
                              input logic [1:0] f2, input logic [4:0] e, input logic [4:0] m,
                              input logic [4:0] w, input logic wbw);
    vec_t x;
    x.v = v; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.rw = rw; x.mr = mr; x.fl = fl;
    x.e_stall = s; x.e_f1 = f1; x.e_f2 = f2; x.e_ex = e; x.e_mem = m; x.e_wb = w;
    x.e_wbw = wbw;
    return x;
  endfunction

  initial begin
    // Load-use on x5: one stall, then MEM forwarding.
    vecs[0]  = mk(1, 1, 2, 5, 1, 1, 0,  0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(1, 5, 0, 8, 1, 0, 0,  1, 1, 0,  5, 0, 0, 0);
    vecs[2]  = mk(1, 5, 0, 8, 1, 0, 0,  0, 2, 0,  0, 5, 0, 0);
    // Three writes to x7: EX wins.
    vecs[3]  = mk(1, 0, 0, 7, 1, 0, 0,  0, 0, 0,  8, 0, 5, 1);
    vecs[4]  = mk(1, 0, 0, 7, 1, 0, 0,  0, 0, 0,  7, 8, 0, 0);
    vecs[5]  = mk(1, 0, 0, 7, 1, 0, 0,  0, 0, 0,  7, 7, 8, 1);
    vecs[6]  = mk(1, 0, 7, 0, 0, 0, 0,  0, 0, 1,  7, 7, 7, 1);
    // Write x3, two non-writers, then WB forwarding.
    vecs[7]  = mk(1, 0, 0, 3, 1, 0, 0,  0, 0, 0,  0, 7, 7, 1);
    vecs[8]  = mk(1, 0, 0, 9, 0, 0, 0,  0, 0, 0,  3, 0, 7, 1);
    vecs[9]  = mk(1, 0, 0, 10, 0, 0, 0, 0, 0, 0,  9, 3, 0, 0);
    vecs[10] = mk(1, 3, 10, 0, 0, 0, 0, 0, 3, 0,  10, 9, 3, 1);
    // Writes to x0 never forward or stall.
    vecs[11] = mk(1, 0, 0, 0, 1, 1, 0,  0, 0, 0,  0, 10, 9, 0);
    vecs[12] = mk(1, 0, 0, 0, 1, 0, 0,  0, 0, 0,  0, 0, 10, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
    // Flush overrides load-use stall.
    vecs[15] = mk(1, 0, 0, 6, 1, 1, 0,  0, 0, 0,  0, 0, 0, 1);
    vecs[16] = mk(1, 6, 6, 11, 1, 0, 1, 0, 1, 1,  6, 0, 0, 0);
    vecs[17] = mk(0, 6, 0, 0, 0, 0, 0,  0, 0, 0,  0, 6, 0, 0);
    vecs[18] = mk(1, 6, 6, 0, 0, 0, 0,  0, 3, 3,  0, 0, 6, 1);

    model_reset();
    #1 rst_n = 1'b0;
    id_valid = 1; id_rs1 = 5; id_rs2 = 6;
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd1", 32'(fwd_rs1), 0);
    chk("rst_fwd2", 32'(fwd_rs2), 0);
    chk("rst_ex_rd", 32'(ex_rd), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_rw", 32'(wb_reg_write), 0);
    id_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rd = vecs[i].rd;
      id_reg_write = vecs[i].rw; id_mem_read = vecs[i].mr; flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_fwd1", i), 32'(fwd_rs1), 32'(vecs[i].e_f1));
      chk($sformatf("v%0d_fwd2", i), 32'(fwd_rs2), 32'(vecs[i].e_f2));
      chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(vecs[i].e_ex));
      chk($sformatf("v%0d_mem_rd", i), 32'(mem_rd), 32'(vecs[i].e_mem));
      chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_wb));
      chk($sformatf("v%0d_wb_rw", i), 32'(wb_reg_write), 32'(vecs[i].e_wbw));
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset while stalled with slots 5/6/7.
    do_reset();
    apply(1, 0, 0, 7, 1, 0, 0);
    apply(1, 0, 0, 6, 1, 0, 0);
    apply(1, 0, 0, 5, 1, 1, 0);
    id_valid = 1; id_rs1 = 5; id_rs2 = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    #1;
    chk("ar_pre_stall", 32'(stall), 1);
    chk("ar_pre_slots", {17'd0, ex_rd, mem_rd, wb_rd}, {17'd0, 5'd5, 5'd6, 5'd7});
    #1 rst_n = 1'b0;
    #1;
    chk("ar_stall", 32'(stall), 0);
    chk("ar_ex_rd", 32'(ex_rd), 0);
    chk("ar_mem_rd", 32'(mem_rd), 0);
    chk("ar_wb_rd", 32'(wb_rd), 0);
    chk("ar_fwd1", 32'(fwd_rs1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(1, 0, 0, 9, 1, 0, 0);
    apply(1, 9, 9, 0, 0, 0, 0);

`ifdef HAZARD_STALL_CNT_EN
    do_reset();
    for (int i = 0; i < 4; i++) load_use(5'(5 + i));
    chk("cnt_four", stall_cnt, 32'd4);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    load_use(12);
    chk("cnt_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 400; i++)
      apply(1'($urandom_range(3) != 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
            5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(7) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
